// File: rtl/avgpool_ctrl.sv
// 2x2 average-pooling sequencer: fetches each window from a 1-cycle-latency buffer and streams the
// AvgUnit result. Each window takes 6 cycles when out_ready is high, and the result is held while out_ready is low.
module avgpool_ctrl #(
  parameter int IN_H       = 4,
  parameter int IN_W       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] numA,
  output logic [DATA_WIDTH-1:0] numB,
  output logic [DATA_WIDTH-1:0] numC,
  output logic [DATA_WIDTH-1:0] numD,
  input  logic [DATA_WIDTH-1:0] avg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam logic [ADDR_WIDTH-1:0] ROW_W   = ADDR_WIDTH'(IN_W);
  localparam logic [ADDR_WIDTH-1:0] OUT_W   = ADDR_WIDTH'(IN_W / 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_OX = ADDR_WIDTH'(IN_W / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_OY = ADDR_WIDTH'(IN_H / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_EMIT, S_DONE} state_t;

  state_t                  state, next_state;
  logic [1:0]              k;
  logic [ADDR_WIDTH-1:0]   oy, ox;
  logic [ADDR_WIDTH-1:0]   base, offs;
  logic                    last_win;

  assign base     = (oy * ROW_W + ox) << 1;
  assign last_win = (oy == LAST_OY) && (ox == LAST_OX);
  assign out_data = avg_in;

  always_comb begin
    offs = '0;
    case (k)
      2'd0:    offs = '0;
      2'd1:    offs = ADDR_WIDTH'(1);
      2'd2:    offs = ROW_W;
      default: offs = ROW_W + ADDR_WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FETCH;
      S_FETCH: if (k == 2'd3) next_state = S_LAST;
      S_LAST:  next_state = S_EMIT;
      S_EMIT:  if (out_ready) next_state = last_win ? S_DONE : S_FETCH;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_FETCH) || (state == S_LAST) || (state == S_EMIT);
    done      = (state == S_DONE);
    rd_en     = (state == S_FETCH);
    rd_addr   = rd_en ? base + offs : '0;
    out_valid = (state == S_EMIT);
    out_addr  = oy * OUT_W + ox;
  end

  // Read data lags its issue by one cycle, so word k-1 is captured while issuing word k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k    <= '0;
      oy   <= '0;
      ox   <= '0;
      numA <= '0;
      numB <= '0;
      numC <= '0;
      numD <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          k  <= '0;
          oy <= '0;
          ox <= '0;
        end
        S_FETCH: begin
          k <= k + 2'd1;
          case (k)
            2'd1:    numA <= rd_data;
            2'd2:    numB <= rd_data;
            2'd3:    numC <= rd_data;
            default: ;
          endcase
        end
        S_LAST: numD <= rd_data;
        S_EMIT: if (out_ready && !last_win) begin
          if (ox == LAST_OX) begin
            ox <= '0;
            oy <= oy + ADDR_WIDTH'(1);
          end else begin
            ox <= ox + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avgpool_ctrl.sv
// Directed bench for avgpool_ctrl: 4x4 map instance plus a 2x2 instance, with a lookup-table AvgUnit.
module tb_avgpool_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, start2, out_ready, out_ready2;
  logic        busy, done, rd_en, out_valid;
  logic [9:0]  rd_addr, out_addr;
  logic [15:0] rd_data, numA, numB, numC, numD, avg_in, out_data;
  logic        busy2, done2, rd_en2, out_valid2;
  logic [9:0]  rd_addr2, out_addr2;
  logic [15:0] rd_data2, numA2, numB2, numC2, numD2, avg_in2, out_data2;

  logic [15:0] mem [16];
  logic [15:0] mem2 [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] avg_lut(input logic [15:0] a, b, c, d);
    case ({a, b, c, d})
      {16'h4000, 16'h4200, 16'h4400, 16'h4500}: return 16'h4300;
      {16'h4600, 16'h4700, 16'h4800, 16'h4880}: return 16'h4780;
      {16'h3C00, 16'h4000, 16'h4200, 16'h4400}: return 16'h4100;
      {16'h4200, 16'h4400, 16'h4500, 16'h4600}: return 16'h4480;
      {16'hBC00, 16'hC000, 16'hC200, 16'hC400}: return 16'hC100;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign avg_in  = avg_lut(numA, numB, numC, numD);
  assign avg_in2 = avg_lut(numA2, numB2, numC2, numD2);

  always @(posedge clk) if (rd_en)  rd_data  <= mem[rd_addr[3:0]];
  always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2[1:0]];

  avgpool_ctrl #(.IN_H(4), .IN_W(4), .DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .numA(numA), .numB(numB), .numC(numC), .numD(numD), .avg_in(avg_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  avgpool_ctrl #(.IN_H(2), .IN_W(2), .DATA_WIDTH(16), .ADDR_WIDTH(10)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .numA(numA2), .numB(numB2), .numC(numC2), .numD(numD2), .avg_in(avg_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_addr(out_addr2)
  );

  logic [15:0] od[$];
  logic [9:0]  oa[$];
  logic [9:0]  ra[$];
  int done_n, done_cnt, w2_n, stall_bad;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then logs reads, handshakes and done for max_n cycles; optionally stalls one output
  // and re-pulses start at cycles xs1/xs2 (0 = never).
  task automatic run(input int stall_addr, input int stall_len, input int xs1, input int xs2, input int max_n);
    int stalls;
    logic [15:0] sd;
    logic [9:0]  sa;
    od.delete(); oa.delete(); ra.delete();
    done_n = -1; done_cnt = 0; w2_n = -1; stall_bad = 0; stalls = 0;
    sd = '0; sa = '0;
    out_ready = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= max_n; n++) begin
      step();
      start = (n == xs1 || n == xs2);
      if (rd_en) begin
        ra.push_back(rd_addr);
        if (rd_addr == 10'd8 && w2_n < 0) w2_n = n;
      end
      out_ready = 1'b1;
      if (out_valid && int'(out_addr) == stall_addr && stalls < stall_len) begin
        if (stalls == 0) begin
          sd = out_data;
          sa = out_addr;
        end else if (out_data !== sd || out_addr !== sa) begin
          stall_bad++;
        end
        stalls++;
        out_ready = 1'b0;
      end
      if (out_valid && out_ready) begin
        oa.push_back(out_addr);
        od.push_back(out_data);
      end
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int d2_n, n_out2;
    logic [9:0] ra2[$];
    logic [15:0] od2;

    mem = '{16'h4000, 16'h4200, 16'h4600, 16'h4700,
            16'h4400, 16'h4500, 16'h4800, 16'h4880,
            16'h3C00, 16'h4000, 16'h4200, 16'h4400,
            16'h4200, 16'h4400, 16'h4500, 16'h4600};
    mem2 = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};
    reset = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_numA", numA, 0);
    chk("rst_numD", numD, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);

    // Basic 4x4 pass
    run(-1, 0, 0, 0, 40);
    chk("t1_n_out", oa.size(), 4);
    chk("t1_addr0", oa[0], 0);  chk("t1_data0", od[0], 16'h4300);
    chk("t1_addr1", oa[1], 1);  chk("t1_data1", od[1], 16'h4780);
    chk("t1_addr2", oa[2], 2);  chk("t1_data2", od[2], 16'h4100);
    chk("t1_addr3", oa[3], 3);  chk("t1_data3", od[3], 16'h4480);
    chk("t1_done_n", done_n, 25);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_n_reads", ra.size(), 16);
    chk("t1_rd0", ra[0], 0); chk("t1_rd1", ra[1], 1);
    chk("t1_rd2", ra[2], 4); chk("t1_rd3", ra[3], 5);
    chk("t1_rd7", ra[7], 7); chk("t1_rd15", ra[15], 15);
    chk("t1_idle_busy", busy, 0);
    chk("t1_hold_numA", numA, 16'h4200);
    chk("t1_hold_numD", numD, 16'h4600);
    chk("t1_idle_rd_addr", rd_addr, 0);

    // Backpressure on window 1 for 5 cycles
    run(1, 5, 0, 0, 50);
    chk("t2_stall_stable", stall_bad, 0);
    chk("t2_n_out", oa.size(), 4);
    chk("t2_addr1", oa[1], 1);
    chk("t2_data1", od[1], 16'h4780);
    chk("t2_w2_fetch_n", w2_n, 18);
    chk("t2_done_n", done_n, 30);

    // start while busy and during DONE
    run(-1, 0, 10, 25, 45);
    chk("t4_n_out", oa.size(), 4);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_n", done_n, 25);
    chk("t4_end_busy", busy, 0);

    // Reset during FETCH of window 2
    start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      start = 1'b0;
    end
    chk("t5_pre_rd_en", rd_en, 1);
    chk("t5_pre_rd_addr", rd_addr, 9);
    reset = 1'b1;
    #1;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_valid", out_valid, 0);
    chk("t5_abort_rd_en", rd_en, 0);
    step();
    chk("t5_no_done", done, 0);
    reset = 1'b0;
    step();
    run(-1, 0, 0, 0, 40);
    chk("t5_rd_first", ra[0], 0);
    chk("t5_addr_first", oa[0], 0);
    chk("t5_n_out", oa.size(), 4);
    chk("t5_done_n", done_n, 25);

    // Negative window at position 0
    mem[0] = 16'hBC00; mem[1] = 16'hC000; mem[4] = 16'hC200; mem[5] = 16'hC400;
    run(-1, 0, 0, 0, 40);
    chk("t3_addr0", oa[0], 0);
    chk("t3_neg_data", od[0], 16'hC100);
    chk("t3_data1", od[1], 16'h4780);

    // 2x2 map on the second instance
    d2_n = -1; n_out2 = 0; od2 = '0;
    start2 = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      step();
      start2 = 1'b0;
      if (rd_en2) ra2.push_back(rd_addr2);
      if (out_valid2 && out_ready2) begin
        n_out2++;
        od2 = out_data2;
      end
      if (done2 && d2_n < 0) d2_n = n;
    end
    chk("t6_n_out", n_out2, 1);
    chk("t6_data", od2, 16'h4300);
    chk("t6_done_n", d2_n, 7);
    chk("t6_n_reads", ra2.size(), 4);
    chk("t6_rd0", ra2[0], 0); chk("t6_rd1", ra2[1], 1);
    chk("t6_rd2", ra2[2], 2); chk("t6_rd3", ra2[3], 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avgpool_ctrl.md
Name: avgpool_ctrl

Overview:
Sequencer for the 2x2 average-pooling stage. It scans an IN_H x IN_W FP16 feature map held in a single-port read buffer (1-cycle read latency). For each non-overlapping 2x2 window it fetches the four words, presents them to the external combinational AvgUnit (numA..numD), and emits the average on a valid/ready output stream with its output-map address. It sits between the convolution output buffer and the pooled-map buffer.

Parameters:
IN_H, 4, input map rows; even, >=2
IN_W, 4, input map columns; even, >=2
DATA_WIDTH, 16, FP16 word width
ADDR_WIDTH, 10, read and output address width; must hold IN_H*IN_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to pool the whole map
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last output handshake
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_WIDTH  read address, row-major r*IN_W+c
rd_data  in  DATA_WIDTH  read data, valid the cycle after rd_en
numA  out  DATA_WIDTH  window top-left to AvgUnit
numB  out  DATA_WIDTH  window top-right
numC  out  DATA_WIDTH  window bottom-left
numD  out  DATA_WIDTH  window bottom-right
avg_in  in  DATA_WIDTH  AvgUnit result (combinational from numA..numD)
out_valid  out  1  pooled result available
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  pooled value, equals avg_in
out_addr  out  ADDR_WIDTH  output index oy*(IN_W/2)+ox

Behaviour:
- Clock clk; reset is asynchronous and active-high. Reset drives all outputs to 0 (busy, done, rd_en, rd_addr, numA..numD, out_valid, out_addr), sets the FSM to IDLE and clears window counters oy, ox.
- FSM states: IDLE, FETCH, LAST, EMIT, DONE.
- IDLE: start=1 -> FETCH. oy=ox=0, k=0, busy=1 next cycle. start is ignored in every other state.
- FETCH (4 cycles, k=0..3): rd_en=1. rd_addr = base, base+1, base+IN_W, base+IN_W+1, where base = 2*oy*IN_W + 2*ox.
  - Captures: rd_data from issue k-1 goes into A, B, C, D in order, at k=1..3.
  - After k=3 -> LAST.
- LAST: rd_en=0. Capture the 4th word into numD -> EMIT.
- EMIT: out_valid=1, out_data=avg_in, out_addr = oy*(IN_W/2)+ox.
  - numA..numD and out_addr stay stable while out_ready=0 (no timeout).
  - On out_valid&&out_ready: if this is the last window -> DONE. Otherwise advance ox (wrapping to 0 and incrementing oy at IN_W/2) -> FETCH with k=0.
- DONE: done=1 for one cycle, busy=0 -> IDLE. A start in DONE is ignored.
- Minimum period is 6 cycles per window with out_ready held high. Total minimum time = 6*(IN_H/2)*(IN_W/2) + 1 cycles from start to done.
- numA..numD hold their last values in IDLE. rd_addr returns to 0 when rd_en=0.
- Reset mid-operation aborts immediately: no done pulse, out_valid drops asynchronously, the next start restarts from window 0.
- No arithmetic on data. Address arithmetic is unsigned ADDR_WIDTH with no wrap within legal parameters.

Test Plan:
1. 4x4 map, rows [2,3,6,7],[4,5,8,9],[1,2,3,4],[3,4,5,6] (FP16), out_ready=1, start -> outputs in order:
   - addr0: 3.5=16'h4300
   - addr1: 7.5=16'h4780
   - addr2: 2.5=16'h4100
   - addr3: 4.5=16'h4480
   - done pulses 25 cycles after start.
   - Read address sequence for window 0 is 0,1,4,5.
2. Backpressure: hold out_ready=0 for 5 cycles during window 1 -> out_valid, out_data=16'h4780 and out_addr=1 stay stable. Window 2 fetch starts only after the handshake. done is delayed by 5 cycles.
3. Negative values: window [-1,-2,-3,-4] (16'hBC00, C000, C200, C400) -> out_data=16'hC100.
4. start asserted while busy and during the DONE cycle -> ignored; exactly 4 outputs, single done pulse.
5. Reset mid-window (during FETCH of window 2) -> busy, out_valid and rd_en go 0 immediately. A new start produces a full sequence beginning at rd_addr 0 and out_addr 0.
6. IN_H=IN_W=2 -> a single output, reads 0,1,2,3, done 7 cycles after start.
